// File: rtl/uriscv_lsu_seq.sv
// Sequential RV32I load/store unit: one op per handshake, single-outstanding word bus,
// optional split of word-crossing accesses, per-access watchdog.
module uriscv_lsu_seq #(
  parameter int SUPPORT_MISALIGNED = 1,
  parameter int TIMEOUT_CYCLES     = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_accept_o,
  input  logic [31:0] opcode_i,
  input  logic [31:0] rs1_val_i,
  input  logic [31:0] rs2_val_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_misaligned_o,
  output logic        resp_error_o,
  output logic [31:0] resp_addr_o,
  output logic        mem_rd_o,
  output logic [3:0]  mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_accept_i,
  input  logic        mem_ack_i,
  input  logic        mem_error_i,
  input  logic [31:0] mem_data_i,
  output logic [2:0]  dbg_state_o
);

  // Handshakes: a request is taken when req_valid_i && req_accept_o at a rising edge;
  // a bus request is held stable until mem_accept_i is high at a rising edge; the
  // response arrives as mem_ack_i (with mem_error_i/mem_data_i) on a later edge.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4
  } state_t;

  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;

  logic [2:0]  f3;
  logic        is_load_dec, is_store_dec, lsu_dec, mis_dec, trap_dec, take;
  logic [31:0] imm_dec, ea_dec;
  logic [1:0]  off_dec;
  logic [7:0]  mask_dec, strb8_dec;
  logic [63:0] lane_dec;

  logic        load_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] ea_q, word0_q;
  logic [7:0]  strb_q;
  logic [63:0] lane_q;
  logic [15:0] wd_q;

  logic        done, done_err, wd_expired, need2, in_second;
  logic [31:0] word0_addr, word1_addr, rd_shift, ld_res;
  logic [63:0] rd_lane;
  logic        unused_bits;

  assign unused_bits = ^{opcode_i[1:0], opcode_i[19:15]};

  // Decode and effective-address generation on the live request inputs.
  always_comb begin
    f3           = opcode_i[14:12];
    is_load_dec  = (opcode_i[6:2] == 5'b00000) && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    is_store_dec = (opcode_i[6:2] == 5'b01000) && !f3[2] && (f3[1:0] != 2'b11);
    lsu_dec      = is_load_dec || is_store_dec;
    imm_dec      = (opcode_i[6:2] == 5'b01000) ?
                   {{20{opcode_i[31]}}, opcode_i[31:25], opcode_i[11:7]} :
                   {{20{opcode_i[31]}}, opcode_i[31:20]};
    ea_dec       = rs1_val_i + imm_dec;
    off_dec      = ea_dec[1:0];
    case (f3[1:0])
      2'b00:   mask_dec = 8'h01;
      2'b01:   mask_dec = 8'h03;
      default: mask_dec = 8'h0F;
    endcase
    strb8_dec = mask_dec << off_dec;
    mis_dec   = ((f3[1:0] == 2'b01) && off_dec[0]) || ((f3[1:0] == 2'b10) && (off_dec != 2'b00));
    trap_dec  = lsu_dec && mis_dec && (SUPPORT_MISALIGNED == 0);
    lane_dec  = is_store_dec ? (64'(rs2_val_i) << {off_dec, 3'b000}) : 64'd0;
  end

  assign need2      = |strb_q[7:4];
  assign wd_expired = WD_EN && (wd_q == WD_LAST);
  assign word0_addr = {ea_q[31:2], 2'b00};
  assign word1_addr = word0_addr + 32'd4;
  assign in_second  = (state_q == S_REQ1) || (state_q == S_WAIT1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    done         = 1'b0;
    done_err     = 1'b0;
    req_accept_o = (state_q == S_IDLE);
    take         = req_valid_i && req_accept_o;
    case (state_q)
      S_IDLE: if (take && lsu_dec && !trap_dec) state_d = S_REQ0;
      S_REQ0: begin
        if (mem_accept_i) state_d = S_WAIT0;
        else if (wd_expired) begin
          state_d = S_IDLE; done = 1'b1; done_err = 1'b1;
        end
      end
      S_WAIT0: begin
        if (mem_ack_i) begin
          if (mem_error_i || !need2) begin
            state_d = S_IDLE; done = 1'b1; done_err = mem_error_i;
          end else begin
            state_d = S_REQ1;
          end
        end else if (wd_expired) begin
          state_d = S_IDLE; done = 1'b1; done_err = 1'b1;
        end
      end
      S_REQ1: begin
        if (mem_accept_i) state_d = S_WAIT1;
        else if (wd_expired) begin
          state_d = S_IDLE; done = 1'b1; done_err = 1'b1;
        end
      end
      S_WAIT1: begin
        if (mem_ack_i) begin
          state_d = S_IDLE; done = 1'b1; done_err = mem_error_i;
        end else if (wd_expired) begin
          state_d = S_IDLE; done = 1'b1; done_err = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_rd_o = load_q && ((state_q == S_REQ0) || (state_q == S_REQ1));
    mem_wr_o = 4'h0;
    if (!load_q && (state_q == S_REQ0))      mem_wr_o = strb_q[3:0];
    else if (!load_q && (state_q == S_REQ1)) mem_wr_o = strb_q[7:4];
    mem_addr_o = in_second ? word1_addr : word0_addr;
    mem_data_o = in_second ? lane_q[63:32] : lane_q[31:0];
  end

  // Load realignment: the second ack supplies the upper word of the 64-bit lane.
  always_comb begin
    rd_lane  = (state_q == S_WAIT1) ? {mem_data_i, word0_q} : {32'd0, mem_data_i};
    rd_shift = 32'(rd_lane >> {ea_q[1:0], 3'b000});
    case (size_q)
      2'b00:   ld_res = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_res = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ld_res = rd_shift;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      load_q            <= 1'b0;
      uns_q             <= 1'b0;
      size_q            <= 2'b00;
      ea_q              <= 32'd0;
      strb_q            <= 8'd0;
      lane_q            <= 64'd0;
      word0_q           <= 32'd0;
      wd_q              <= 16'd0;
      resp_valid_o      <= 1'b0;
      resp_data_o       <= 32'd0;
      resp_misaligned_o <= 1'b0;
      resp_error_o      <= 1'b0;
      resp_addr_o       <= 32'd0;
    end else begin
      resp_valid_o      <= 1'b0;
      resp_misaligned_o <= 1'b0;
      resp_error_o      <= 1'b0;
      if (take) begin
        load_q <= is_load_dec;
        uns_q  <= f3[2];
        size_q <= f3[1:0];
        ea_q   <= ea_dec;
        strb_q <= strb8_dec;
        lane_q <= lane_dec;
        // Traps and non-LSU ops complete straight from IDLE without a bus op.
        if (!lsu_dec || trap_dec) begin
          resp_valid_o      <= 1'b1;
          resp_misaligned_o <= trap_dec;
          resp_data_o       <= 32'd0;
          resp_addr_o       <= ea_dec;
        end
      end
      if ((state_q == S_WAIT0) && mem_ack_i) word0_q <= mem_data_i;
      if (done) begin
        resp_valid_o <= 1'b1;
        resp_error_o <= done_err;
        resp_addr_o  <= ea_q;
        resp_data_o  <= (load_q && !done_err) ? ld_res : 32'd0;
      end
      if ((state_d != state_q) && ((state_d == S_REQ0) || (state_d == S_REQ1)))
        wd_q <= 16'd0;
      else if (state_q != S_IDLE)
        wd_q <= wd_q + 16'd1;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uriscv_lsu_seq.sv
// Directed bench for uriscv_lsu_seq: one instance with misaligned support and an
// 8-cycle watchdog, one instance that traps misaligned accesses.
module tb_uriscv_lsu_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_accept, resp_valid, resp_mis, resp_err;
  logic [31:0] opcode, rs1_val, rs2_val, resp_data, resp_addr;
  logic        mem_rd, mem_accept, mem_ack, mem_error;
  logic [3:0]  mem_wr;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [2:0]  dbg_state;

  logic        m0_req_valid, m0_req_accept, m0_resp_valid, m0_resp_mis, m0_resp_err;
  logic [31:0] m0_resp_data, m0_resp_addr, m0_mem_addr, m0_mem_data;
  logic        m0_mem_rd, m0_ack, m0_pend;
  logic        m0_accept = 1'b1;
  logic        m0_error  = 1'b0;
  logic [31:0] m0_rdata  = 32'h0;
  logic [3:0]  m0_mem_wr;
  logic [2:0]  m0_dbg_state;

  uriscv_lsu_seq #(.SUPPORT_MISALIGNED(1), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_accept_o(req_accept),
    .opcode_i(opcode), .rs1_val_i(rs1_val), .rs2_val_i(rs2_val),
    .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_misaligned_o(resp_mis),
    .resp_error_o(resp_err), .resp_addr_o(resp_addr),
    .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr), .mem_data_o(mem_data),
    .mem_accept_i(mem_accept), .mem_ack_i(mem_ack), .mem_error_i(mem_error),
    .mem_data_i(mem_rdata), .dbg_state_o(dbg_state)
  );

  uriscv_lsu_seq #(.SUPPORT_MISALIGNED(0), .TIMEOUT_CYCLES(0)) dut_m0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(m0_req_valid), .req_accept_o(m0_req_accept),
    .opcode_i(opcode), .rs1_val_i(rs1_val), .rs2_val_i(rs2_val),
    .resp_valid_o(m0_resp_valid), .resp_data_o(m0_resp_data), .resp_misaligned_o(m0_resp_mis),
    .resp_error_o(m0_resp_err), .resp_addr_o(m0_resp_addr),
    .mem_rd_o(m0_mem_rd), .mem_wr_o(m0_mem_wr), .mem_addr_o(m0_mem_addr), .mem_data_o(m0_mem_data),
    .mem_accept_i(m0_accept), .mem_ack_i(m0_ack), .mem_error_i(m0_error),
    .mem_data_i(m0_rdata), .dbg_state_o(m0_dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Bus responder for the main instance: accepts at once unless held, acks one cycle later.
  bit          hold_accept = 0, err_arm = 0, stray_ack = 0, pending = 0, pend_err = 0;
  logic [31:0] pend_data;
  int          rd_cycles = 0;
  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] acc_addr[$];
  logic [3:0]  acc_wr[$];
  logic [31:0] acc_data[$];
  logic [31:0] exp_q[$];

  initial begin
    mem_accept = 0; mem_ack = 0; mem_error = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_ack = 0; mem_error = 0;
      if (pending) begin
        mem_ack = 1; mem_error = pend_err; mem_rdata = pend_data; pending = 0;
      end else if (stray_ack) begin
        mem_ack = 1; mem_rdata = 32'hBADBAD00; stray_ack = 0;
      end
      if (mem_rd) rd_cycles++;
      mem_accept = 0;
      if (!rst && !hold_accept && (mem_rd || mem_wr != 4'h0)) begin
        mem_accept = 1; pending = 1; pend_err = err_arm; err_arm = 0;
        pend_data = mem_words.exists(mem_addr) ? mem_words[mem_addr] : 32'h0;
        acc_addr.push_back(mem_addr); acc_wr.push_back(mem_wr); acc_data.push_back(mem_data);
      end
    end
  end

  int m0_bus = 0;
  initial begin
    m0_ack = 0; m0_pend = 0;
    forever begin
      @(negedge clk);
      m0_ack  = m0_pend;
      m0_pend = m0_mem_rd || (m0_mem_wr != 4'h0);
      if (m0_pend) m0_bus++;
    end
  end

  function automatic logic [31:0] enc_load(input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd1, f3, 5'd2, 7'b0000011};
  endfunction

  function automatic logic [31:0] enc_store(input logic [2:0] f3, input logic [11:0] imm);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  logic [31:0] r_data, r_addr;
  logic        r_mis, r_err;
  int          r_lat;

  task automatic clear_log();
    acc_addr.delete(); acc_wr.delete(); acc_data.delete(); exp_q.delete();
    rd_cycles = 0; m0_bus = 0;
  endtask

  // Issues one op; r_lat counts negedges after the accepting edge until resp_valid.
  task automatic run_op(input bit on_m0, input logic [31:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input int extra);
    logic v;
    @(negedge clk);
    check("accept_idle", on_m0 ? m0_req_accept : req_accept, 32'd1);
    opcode = opc; rs1_val = a; rs2_val = b;
    if (on_m0) m0_req_valid = 1; else req_valid = 1;
    @(negedge clk);
    r_lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (r_lat > extra) begin req_valid = 0; m0_req_valid = 0; end
      v = on_m0 ? m0_resp_valid : resp_valid;
      if (v) break;
      @(negedge clk);
      r_lat++;
    end
    req_valid = 0; m0_req_valid = 0;
    check("resp_seen", {31'd0, v}, 32'd1);
    check("accept_at_resp", on_m0 ? m0_req_accept : req_accept, 32'd1);
    r_data = on_m0 ? m0_resp_data : resp_data;
    r_addr = on_m0 ? m0_resp_addr : resp_addr;
    r_mis  = on_m0 ? m0_resp_mis  : resp_mis;
    r_err  = on_m0 ? m0_resp_err  : resp_err;
  endtask

  task automatic check_resp(input string tag, input int lat, input logic [31:0] data,
                            input logic [31:0] addr, input logic mis, input logic err);
    check({tag, "_lat"},  32'(r_lat), 32'(lat));
    check({tag, "_data"}, r_data, data);
    check({tag, "_addr"}, r_addr, addr);
    check({tag, "_mis"},  {31'd0, r_mis}, {31'd0, mis});
    check({tag, "_err"},  {31'd0, r_err}, {31'd0, err});
  endtask

  task automatic check_acc(input string tag);
    check({tag, "_nacc"}, 32'(acc_addr.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && acc_addr.size() > 0)
      check({tag, "_bus_addr"}, acc_addr.pop_front(), exp_q.pop_front());
  endtask

  initial begin
    rst = 1; req_valid = 0; m0_req_valid = 0; opcode = 0; rs1_val = 0; rs2_val = 0;
    mem_words[32'h0000_1004] = 32'hDEADBEEF;
    mem_words[32'h0000_3000] = 32'h11223344;
    mem_words[32'h0000_3004] = 32'h55667788;
    repeat (3) @(negedge clk);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_wr", {28'd0, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    rst = 0;
    @(negedge clk);
    check("rst_accept", {31'd0, req_accept}, 32'd1);
    check("rst_state", {29'd0, dbg_state}, 32'd0);

    // Aligned LW, with req_valid held into REQ0 to show it is ignored there
    clear_log(); exp_q.push_back(32'h1004);
    run_op(0, enc_load(3'b010, 12'd4), 32'h1000, 32'h0, 1);
    check_resp("lw", 3, 32'hDEADBEEF, 32'h1004, 0, 0);
    if (acc_wr.size() > 0) check("lw_wr", {28'd0, acc_wr[0]}, 32'd0);
    check_acc("lw");

    clear_log(); exp_q.push_back(32'h2000);
    run_op(0, enc_store(3'b000, 12'd0), 32'h2003, 32'h1234_56AB, 0);
    check_resp("sb", 3, 32'h0, 32'h2003, 0, 0);
    if (acc_wr.size() > 0) begin
      check("sb_wr", {28'd0, acc_wr[0]}, 32'h8);
      check("sb_data", acc_data[0], 32'hAB00_0000);
    end
    check_acc("sb");

    clear_log(); exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    run_op(0, enc_load(3'b101, 12'd0), 32'h3003, 32'h0, 0);
    check_resp("lhu_split", 5, 32'h0000_8811, 32'h3003, 0, 0);
    check_acc("lhu_split");

    clear_log(); exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    run_op(0, enc_load(3'b001, 12'd0), 32'h3003, 32'h0, 0);
    check_resp("lh_split", 5, 32'hFFFF_8811, 32'h3003, 0, 0);
    check_acc("lh_split");

    clear_log(); exp_q.push_back(32'h3000); exp_q.push_back(32'h3004);
    run_op(0, enc_load(3'b010, 12'd0), 32'h3002, 32'h0, 0);
    check_resp("lw_split", 5, 32'h7788_1122, 32'h3002, 0, 0);
    check_acc("lw_split");

    clear_log(); exp_q.push_back(32'h3004);
    run_op(0, enc_load(3'b000, 12'hFFC), 32'h3008, 32'h0, 0);
    check_resp("lb_neg", 3, 32'hFFFF_FF88, 32'h3004, 0, 0);
    check_acc("lb_neg");

    clear_log(); exp_q.push_back(32'h3004);
    run_op(0, enc_load(3'b100, 12'hFFC), 32'h3008, 32'h0, 0);
    check_resp("lbu", 3, 32'h0000_0088, 32'h3004, 0, 0);
    check_acc("lbu");

    clear_log(); exp_q.push_back(32'h5000);
    run_op(0, enc_store(3'b001, 12'd0), 32'h5001, 32'h0000_BEEF, 0);
    check_resp("sh_off1", 3, 32'h0, 32'h5001, 0, 0);
    if (acc_wr.size() > 0) begin
      check("sh_off1_wr", {28'd0, acc_wr[0]}, 32'h6);
      check("sh_off1_data", acc_data[0], 32'h00BE_EF00);
    end
    check_acc("sh_off1");

    // Wrapping SW with error on the first half: second half never issued
    clear_log(); err_arm = 1; exp_q.push_back(32'hFFFF_FFFC);
    run_op(0, enc_store(3'b010, 12'hFFE), 32'h0, 32'hAABB_CCDD, 0);
    check_resp("sw_err", 3, 32'h0, 32'hFFFF_FFFE, 0, 1);
    if (acc_wr.size() > 0) begin
      check("sw_err_wr", {28'd0, acc_wr[0]}, 32'hC);
      check("sw_err_data", acc_data[0], 32'hCCDD_0000);
    end
    check_acc("sw_err");

    clear_log(); exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    run_op(0, enc_store(3'b010, 12'hFFE), 32'h0, 32'hAABB_CCDD, 0);
    check_resp("sw_wrap", 5, 32'h0, 32'hFFFF_FFFE, 0, 0);
    if (acc_wr.size() > 1) begin
      check("sw_wrap_wr1", {28'd0, acc_wr[1]}, 32'h3);
      check("sw_wrap_data1", acc_data[1], 32'h0000_AABB);
    end
    check_acc("sw_wrap");

    clear_log();
    run_op(0, 32'h0000_0013, 32'h77, 32'h0, 0);
    check_resp("non_lsu", 1, 32'h0, 32'h77, 0, 0);
    check_acc("non_lsu");

    // Watchdog: request never accepted
    clear_log(); hold_accept = 1;
    run_op(0, enc_load(3'b010, 12'd0), 32'h6000, 32'h0, 0);
    check_resp("wd", 9, 32'h0, 32'h6000, 0, 1);
    check("wd_rd_cycles", 32'(rd_cycles), 32'd8);
    check("wd_rd_dropped", {31'd0, mem_rd}, 32'd0);
    hold_accept = 0;
    check_acc("wd");

    // Ack while idle must be ignored
    stray_ack = 1;
    repeat (3) @(negedge clk);
    check("stray_state", {29'd0, dbg_state}, 32'd0);
    check("stray_resp", {31'd0, resp_valid}, 32'd0);
    clear_log(); exp_q.push_back(32'h1004);
    run_op(0, enc_load(3'b010, 12'd0), 32'h1004, 32'h0, 0);
    check_resp("lw_after_stray", 3, 32'hDEADBEEF, 32'h1004, 0, 0);
    check_acc("lw_after_stray");

    // Trapping instance
    clear_log();
    run_op(1, enc_store(3'b010, 12'd2), 32'h4000, 32'hAABB_CCDD, 0);
    check_resp("m0_sw_trap", 1, 32'h0, 32'h4002, 1, 0);
    check("m0_sw_nobus", 32'(m0_bus), 32'd0);

    clear_log();
    run_op(1, enc_load(3'b001, 12'd1), 32'h4000, 32'h0, 0);
    check_resp("m0_lh_trap", 1, 32'h0, 32'h4001, 1, 0);
    check("m0_lh_nobus", 32'(m0_bus), 32'd0);

    clear_log();
    run_op(1, enc_load(3'b010, 12'd0), 32'h4000, 32'h0, 0);
    check_resp("m0_lw", 3, 32'h0, 32'h4000, 0, 0);
    check("m0_lw_bus", 32'(m0_bus), 32'd1);
    check("m0_lw_addr_idle", m0_mem_addr, 32'h4000);
    check("m0_lw_state", {29'd0, m0_dbg_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end

endmodule
